// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions for the single-issue RISC-V core.
package riscv_pkg;

   localparam int          XLEN        = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int          INSTR_BYTES = 4;

   // IDLE: may request, WAIT: response owed to decode,
   // HOLD: instruction presented, KILL: response owed but stale
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Next-PC arithmetic: sequential increment and PC-relative redirect target.
module pc_next #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] base,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] target,
   output logic            misalign
);
   import riscv_pkg::*;

   logic [XLEN-1:0] sum;

   // Target wraps modulo 2^XLEN; low bits are dropped to keep fetch word aligned
   assign sum      = base + imm;
   assign pc_plus4 = pc + XLEN'(INSTR_BYTES);
   assign target   = {sum[XLEN-1:2], 2'b00};
   assign misalign = |sum[1:0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, one instruction held for decode.
module fetch_ctrl #(
   parameter int             XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            halt,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_base,
   input  logic [XLEN-1:0] redir_imm,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic            misalign_err
);
   import riscv_pkg::*;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] target;
   logic            misalign;
   logic            take_rsp;

   pc_next #(.XLEN(XLEN)) u_pc_next (
      .pc       (pc_q),
      .base     (redir_base),
      .imm      (redir_imm),
      .pc_plus4 (pc_plus4),
      .target   (target),
      .misalign (misalign)
   );

   // The request address is always the architectural PC; it only moves on
   // a delivered response or a redirect, so it is stable while stalled.
   assign imem_req_addr = pc_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs; redirect outranks every other event
   always_comb begin
      state_nxt      = state;
      imem_req_valid = 1'b0;
      if_valid       = 1'b0;
      take_rsp       = 1'b0;
      case (state)
         IDLE: begin
            imem_req_valid = !halt && !redir_valid;
            if (!redir_valid && imem_req_valid && imem_req_ready)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (redir_valid) begin
               // a response arriving with the redirect is already stale
               state_nxt = imem_rsp_valid ? IDLE : KILL;
            end else if (imem_rsp_valid) begin
               take_rsp  = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if_valid = 1'b1;
            // a redirect drops the instruction even if decode grabs it
            if (redir_valid || if_ready)
               state_nxt = IDLE;
         end
         KILL: begin
            if (!redir_valid && imem_rsp_valid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // PC, presented instruction and misalign pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         if_pc        <= '0;
         if_instr     <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redir_valid && misalign;
         if (redir_valid) begin
            pc_q <= target;
         end else if (take_rsp) begin
            if_pc    <= pc_q;
            if_instr <= imem_rsp_data;
            pc_q     <= pc_plus4;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a transaction-level reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halt;
   logic        redir_valid;
   logic [31:0] redir_base;
   logic [31:0] redir_imm;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_err;

   fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .halt           (halt),
      .redir_valid    (redir_valid),
      .redir_base     (redir_base),
      .redir_imm      (redir_imm),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .misalign_err   (misalign_err)
   );

   // clock
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model: what is owed by memory / held for decode
   logic [31:0] m_pc, m_ipc, m_instr;
   bit          m_busy, m_stale, m_held, m_mis;

   // memory responder
   int          rsp_lat = 1;
   int          cnt     = 0;
   logic [31:0] raddr;

   // values sampled at the last negedge
   bit          s_req_valid, s_if_valid, s_mis, s_accept;
   logic [31:0] s_addr, s_ifpc, s_instr;

   int          acc_cyc[$], vld_cyc[$];
   logic [31:0] acc_addr[$], vld_pc[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: condition not reached (cycle %0d)", name, cyc);
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_ipc = '0; m_instr = '0;
      m_busy = 0; m_stale = 0; m_held = 0; m_mis = 0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      tgt   = redir_base + redir_imm;
      m_mis = redir_valid && (tgt[1:0] != 2'b00);
      if (redir_valid) begin
         m_pc   = tgt & 32'hFFFF_FFFC;
         m_held = 0;
         if (m_busy) begin
            if (imem_rsp_valid) begin m_busy = 0; m_stale = 0; end
            else m_stale = 1;
         end
      end else if (!m_busy && !m_held) begin
         if (!halt && imem_req_ready) begin m_busy = 1; m_stale = 0; end
      end else if (m_busy) begin
         if (imem_rsp_valid) begin
            if (!m_stale) begin
               m_held  = 1;
               m_ipc   = m_pc;
               m_instr = imem_rsp_data;
               m_pc    = m_pc + 32'd4;
            end
            m_busy  = 0;
            m_stale = 0;
         end
      end else if (m_held && if_ready) begin
         m_held = 0;
      end
   endtask

   // one clock: compare at negedge, advance model at posedge, drive at +1
   task automatic tick();
      bit exp_rv;
      @(negedge clk);
      exp_rv = !m_busy && !m_held && !halt && !redir_valid;
      chk("imem_req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("imem_req_addr", imem_req_addr, m_pc);
      chk("if_valid", if_valid, m_held);
      chk("if_pc", if_pc, m_ipc);
      chk("if_instr", if_instr, m_instr);
      chk("misalign_err", misalign_err, m_mis);
      s_req_valid = imem_req_valid;
      s_addr      = imem_req_addr;
      s_if_valid  = if_valid;
      s_ifpc      = if_pc;
      s_instr     = if_instr;
      s_mis       = misalign_err;
      s_accept    = imem_req_valid && imem_req_ready;
      if (s_accept) begin acc_cyc.push_back(cyc); acc_addr.push_back(imem_req_addr); end
      if (if_valid) begin vld_cyc.push_back(cyc); vld_pc.push_back(if_pc); end
      @(posedge clk);
      if (rst_n) model_step();
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      if (s_accept) begin cnt = rsp_lat; raddr = s_addr; end
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = raddr ^ 32'h1300_0013;
         end
      end
   endtask

   task automatic quiesce();
      halt = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      logic [31:0] pc0, ins0;
      bit          seen;
      rst_n = 1'b0; halt = 1'b1; redir_valid = 1'b0; redir_base = '0; redir_imm = '0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b1;
      model_reset();
      tick(); tick();
      chk("rst_req_valid", s_req_valid, 0);
      chk("rst_if_valid", s_if_valid, 0);
      chk("rst_if_pc", s_ifpc, 0);
      chk("rst_if_instr", s_instr, 0);
      chk("rst_misalign", s_mis, 0);

      // streaming fetch: 0x0, 0x4, 0x8 with 2-cycle accept-to-valid
      rst_n = 1'b1; halt = 1'b0;
      acc_cyc.delete(); acc_addr.delete(); vld_cyc.delete(); vld_pc.delete();
      repeat (12) tick();
      if (acc_addr.size() >= 3 && vld_cyc.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("t1_addr", acc_addr[i], 32'(4 * i));
            chk("t1_latency", 32'(vld_cyc[i] - acc_cyc[i]), 2);
            chk("t1_if_pc", vld_pc[i], acc_addr[i]);
         end
      end else fail("t1_three_fetches");

      // memory not ready: request held (model checks address stability)
      imem_req_ready = 1'b0;
      repeat (4) tick();
      imem_req_ready = 1'b1;
      quiesce();

      // decode stall in HOLD
      halt = 1'b0; if_ready = 1'b0;
      for (int n = 0; n < 10 && !s_if_valid; n++) tick();
      if (!s_if_valid) fail("t2_if_valid");
      else begin
         pc0 = s_ifpc; ins0 = s_instr;
         repeat (5) begin
            tick();
            chk("t2_hold_valid", s_if_valid, 1);
            chk("t2_hold_pc", s_ifpc, pc0);
            chk("t2_hold_instr", s_instr, ins0);
            chk("t2_no_req", s_req_valid, 0);
         end
      end
      if_ready = 1'b1;
      tick();
      quiesce();

      // redirect in WAIT, stale response 3 cycles later
      rsp_lat = 4; halt = 1'b0;
      for (int n = 0; n < 10 && !s_accept; n++) tick();
      if (!s_accept) fail("t3_accept");
      redir_valid = 1'b1; redir_base = 32'h100; redir_imm = 32'h20;
      tick();
      redir_valid = 1'b0; rsp_lat = 1; seen = 0;
      for (int n = 0; n < 10 && !s_req_valid; n++) begin tick(); seen |= s_if_valid; end
      if (!s_req_valid) fail("t3_next_req");
      chk("t3_addr", s_addr, 32'h120);
      chk("t3_no_if_valid", seen, 0);
      quiesce();

      // wrap-around target
      redir_valid = 1'b1; redir_base = 32'hFFFF_FFF0; redir_imm = 32'h14;
      tick();
      redir_valid = 1'b0; halt = 1'b0;
      tick();
      chk("t4_misalign", s_mis, 0);
      chk("t4_req_valid", s_req_valid, 1);
      chk("t4_addr", s_addr, 32'h4);
      quiesce();

      // misaligned target, redirect suppresses IDLE request
      halt = 1'b0;
      redir_valid = 1'b1; redir_base = 32'h200; redir_imm = 32'h6;
      tick();
      chk("t5_req_suppressed", s_req_valid, 0);
      redir_valid = 1'b0;
      tick();
      chk("t5_misalign", s_mis, 1);
      chk("t5_req_valid", s_req_valid, 1);
      chk("t5_addr", s_addr, 32'h204);
      tick();
      chk("t5_misalign_pulse", s_mis, 0);
      quiesce();

      // redirect in HOLD with a simultaneous decode handshake
      halt = 1'b0; if_ready = 1'b0;
      for (int n = 0; n < 10 && !s_if_valid; n++) tick();
      if (!s_if_valid) fail("t7_if_valid");
      redir_valid = 1'b1; redir_base = 32'h40; redir_imm = 32'h0; if_ready = 1'b1;
      tick();
      redir_valid = 1'b0;
      tick();
      chk("t7_dropped", s_if_valid, 0);
      chk("t7_req_valid", s_req_valid, 1);
      chk("t7_addr", s_addr, 32'h40);
      quiesce();

      // redirect in WAIT coinciding with the response
      halt = 1'b0; rsp_lat = 1;
      for (int n = 0; n < 10 && !s_accept; n++) tick();
      if (!s_accept) fail("t8_accept");
      redir_valid = 1'b1; redir_base = 32'h80; redir_imm = 32'h0;
      tick();
      redir_valid = 1'b0;
      tick();
      chk("t8_no_if_valid", s_if_valid, 0);
      chk("t8_req_valid", s_req_valid, 1);
      chk("t8_addr", s_addr, 32'h80);
      quiesce();

      // reset while WAIT, response lands after release
      rsp_lat = 4; halt = 1'b0;
      for (int n = 0; n < 10 && !s_accept; n++) tick();
      if (!s_accept) fail("t6_accept");
      halt = 1'b1;
      tick();
      rst_n = 1'b0; model_reset();
      tick();
      chk("t6_rst_if_valid", s_if_valid, 0);
      rst_n = 1'b1; seen = 0;
      repeat (6) begin tick(); seen |= s_if_valid; end
      chk("t6_late_rsp_ignored", seen, 0);
      halt = 1'b0; rsp_lat = 1;
      tick();
      chk("t6_req_valid", s_req_valid, 1);
      chk("t6_addr", s_addr, RST_PC);
      quiesce();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch port for the single-issue RISC-V core.
- Holds the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Presents each returned instruction to decode over a valid/ready handshake.
- Applies PC-relative branch/jump redirects (base + immediate) from execute and discards any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- halt  in  1  when high, no new fetch requests are issued.
- redir_valid  in  1  redirect request, single-cycle pulse.
- redir_base  in  XLEN  PC of the redirecting branch/jump.
- redir_imm  in  XLEN  sign-extended immediate offset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  instruction data returned, single-cycle pulse.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- misalign_err  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, pc_q = RESET_PC.
  - imem_req_valid = 0, if_valid = 0, misalign_err = 0, if_pc = 0, if_instr = 0.
- At most one outstanding memory request. imem_req_addr = pc_q whenever imem_req_valid is high.
- States and transitions:
  - IDLE: imem_req_valid = !halt && !redir_valid. On req accept (valid && ready) -> WAIT. Any imem_rsp_valid seen in IDLE is ignored.
  - WAIT: on imem_rsp_valid, latch if_instr = rsp_data and if_pc = pc_q, set pc_q = pc_q + 4, -> HOLD.
  - HOLD: if_valid = 1, with if_pc and if_instr stable until handshake. On if_valid && if_ready -> IDLE.
  - KILL: waits for the stale response. On imem_rsp_valid, discard the data -> IDLE.
- Latency and throughput:
  - Request accepted in cycle N; response earliest N+1; if_valid asserted N+2.
  - Next request issued the cycle after the decode handshake.
- Redirect:
  - target = redir_base + redir_imm, modulo 2^32 (wrap-around, no overflow flag).
  - pc_q <= {target[31:2], 2'b00}.
  - misalign_err = 1 on the next cycle iff target[1:0] != 0.
  - Redirect has priority over every other event in the same cycle.
- Redirect action per state:
  - IDLE: request suppressed this cycle; stay IDLE.
  - WAIT, no rsp this cycle: -> KILL.
  - WAIT, rsp_valid in the same cycle: discard the response -> IDLE.
  - HOLD: drop the held instruction; if_valid low the next cycle -> IDLE. The decode handshake in that same cycle does not count as an accept.
  - KILL: pc_q updated again; stay KILL.
- halt:
  - Gates new requests only. Outstanding responses complete and are delivered.
  - halt does not affect redirects.
- imem_req_ready low: imem_req_valid and imem_req_addr held stable until accepted, unless a redirect arrives.
- Reset mid-operation: returns to IDLE immediately. A late response after reset falls in IDLE and is ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN.
  - RESET_PC default.
  - INSTR_BYTES = 4.
  - enum fetch_state_t {IDLE, WAIT, HOLD, KILL}.
- One sub-module, pc_next:
  - Combinational.
  - Computes pc_q + 4 and redir_base + redir_imm.
  - Aligns the target and produces the misalign flag.

Test Plan:
- Reset, then memory always ready and returning rsp one cycle after accept, decode always ready -> addresses 0x0, 0x4, 0x8; each if_valid asserted 2 cycles after accept, with if_pc matching the address.
- Decode stalls (if_ready = 0) for 5 cycles in HOLD -> if_valid stays high, if_instr/if_pc stable, no new imem request issued.
- Redirect in WAIT (base 0x100, imm 0x20), response arrives 3 cycles later -> response discarded, if_valid stays 0; next request addr = 0x120.
- Redirect with base 0xFFFF_FFF0, imm 0x14 -> next request addr = 0x0000_0004 (wrap-around); misalign_err = 0.
- Redirect with base 0x200, imm 0x6 -> next request addr = 0x204; misalign_err pulses exactly 1 cycle.
- rst_n asserted while in WAIT, memory returns rsp after rst_n release -> if_valid never asserted for it; first request addr = RESET_PC.
